serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
- Bit-serial N-bit adder/subtractor: latches two operands and processes one bit per clock, LSB first, through a single full-adder cell with a registered carry.
- Sits in the adder/subtractor datapath as the sequential stage that feeds the 1-bit full-adder cell and collects its sum/carry.
- Provides an area-cheap alternative to a ripple-carry array.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- sub  input  1  0 = a+b, 1 = a-b; sampled with start
- a_in  input  WIDTH  operand A; sampled with start
- b_in  input  WIDTH  operand B; sampled with start
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse, result valid
- result  output  WIDTH  sum/difference; held until next accepted start
- carry_out  output  1  final carry (for sub: 1 = no borrow, a>=b unsigned)
- ovf  output  1  signed overflow (only with SERIAL_ADDSUB_OVF_EN)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, carry_out=0, ovf=0; operand shifters, carry register and bit counter cleared. Takes effect immediately, including mid-operation; the in-flight operation is discarded and no done is produced.
- States: IDLE, SHIFT, DONE.
- IDLE -> SHIFT on an edge with start=1. At that edge:
  - load A register with a_in;
  - load B register with b_in, or with ~b_in if sub=1;
  - carry register <= sub, giving two's-complement +1;
  - counter <= 0.
  - result is not cleared; it is overwritten as bits arrive.
- SHIFT, each edge:
  - s = A[0]^B[0]^c; c <= majority(A[0],B[0],c);
  - A and B shift right by 1;
  - s shifts into result at the MSB (result <= {s, result[WIDTH-1:1]});
  - counter++.
  - After the WIDTH-th SHIFT edge: state <= DONE; carry_out <= final carry.
- DONE: done=1 for exactly one cycle, busy=0; next edge -> IDLE unconditionally.
- Latency: start accepted at edge k -> done high between edges k+WIDTH and k+WIDTH+1. Throughput: one operation per WIDTH+2 cycles.
- start in SHIFT or DONE is ignored; no queuing. sub, a_in and b_in are don't-care outside the accepting edge.
- busy is a registered decode of SHIFT; done is a registered decode of DONE. No combinational input-to-output paths.
- Arithmetic is modulo 2^WIDTH; result bits are final only when done=1. During SHIFT, result holds a partially shifted value and consumers must not sample it.
- Counter width is clog2(WIDTH)+1; there is no wrap hazard.

Optional Feature:
- Macro: SERIAL_ADDSUB_OVF_EN.
- Defined:
  - ovf port exists.
  - During the last SHIFT edge, ovf <= carry-into-MSB XOR carry-out-of-MSB.
  - ovf is valid with done and held until the next accepted start, where it clears to 0.
- Undefined: ovf port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package (addsub_pkg):
  - state enum {IDLE, SHIFT, DONE};
  - OP_ADD=1'b0 and OP_SUB=1'b1 constants;
  - default width constant ADDSUB_W=8.
- Sub-module: fa_cell, a combinational 1-bit full adder (a, b, cin -> s, cout), instantiated once for the serial bit slice.
- The top module holds the FSM, shift registers, carry flop and counter.

Test Plan:
- Add, WIDTH=8: a=0x3C, b=0x0F, sub=0 -> done exactly 8 cycles after the start edge; result=0x4B, carry_out=0, busy high for 8 cycles.
- Add wrap: a=0xFF, b=0x01 -> result=0x00, carry_out=1; with SERIAL_ADDSUB_OVF_EN, ovf=0. Also 0x7F+0x01 -> result=0x80, ovf=1.
- Subtract: 0x10-0x01 -> result=0x0F, carry_out=1. Then 0x01-0x02 -> result=0xFF, carry_out=0 (borrow). With OVF_EN: 0x80-0x01 -> result=0x7F, ovf=1.
- start held high continuously with new operands: second operation accepted only on the edge after done's cycle (IDLE). Operands presented while busy=1 are ignored; first result is unchanged.
- rst_n pulsed low at SHIFT cycle 4 of 0x3C+0x0F -> all outputs 0 immediately; no done pulse. A fresh start of 0x01+0x01 after release -> result=0x02.
- Back-to-back random unsigned/signed ops (≥1000) -> result, carry_out and ovf match the reference model; done width always 1 cycle.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// addsub_pkg: definitions shared by the bit-serial adder/subtractor.
//   state_e  : IDLE / SHIFT / DONE sequencing states
//   OP_ADD   : value of sub that selects a + b
//   OP_SUB   : value of sub that selects a - b
//   ADDSUB_W : default operand/result width
package addsub_pkg;

  localparam int   ADDSUB_W = 8;
  localparam logic OP_ADD   = 1'b0;
  localparam logic OP_SUB   = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// fa_cell: combinational 1-bit full adder used as the serial bit slice.
//   a, b, cin : addend bits and carry in
//   s         : sum bit
//   cout      : carry out (majority of a, b, cin)
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial WIDTH-bit adder/subtractor, one bit per clock,
// LSB first, through a single full-adder cell with a registered carry.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled only in IDLE
//   sub        : 0 = a+b, 1 = a-b (sampled with start)
//   a_in, b_in : operands (sampled with start)
//   busy       : high while shifting
//   done       : one-cycle pulse, result valid
//   result     : sum/difference, held until next accepted start
//   carry_out  : final carry (subtract: 1 = no borrow)
//   ovf        : signed overflow, present only when SERIAL_ADDSUB_OVF_EN
//                is defined
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; result/carry_out/ovf hold last values
// SHIFT | one bit per edge through fa_cell, WIDTH edges total
// DONE  | done pulse for one cycle, then back to IDLE unconditionally
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_s;
  logic fa_cout;

  fa_cell u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          a_d     = a_in;
          // Subtract as a + ~b + 1: the +1 enters through the carry flop.
          b_d     = (sub == OP_SUB) ? ~b_in : b_in;
          c_d     = sub;
          cnt_d   = '0;
`ifdef SERIAL_ADDSUB_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      SHIFT: begin
        c_d      = fa_cout;
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        result_d = {fa_s, result_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d     = DONE;
          carry_out_d = fa_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
          // On the MSB slice c_q is the carry into the sign bit.
          ovf_d       = c_q ^ fa_cout;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed and random checks of serial_addsub with a
// scoreboard queue of expected results. Build with SERIAL_ADDSUB_OVF_EN
// defined to also check the ovf output.
module tb_serial_addsub;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub_in;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic         ovf;
`endif

  int   total;
  int   bad;
  exp_t sb_q[$];

  serial_addsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out)
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    exp_t       e;
    logic [W:0] s;
    if (sub) s = {1'b0, a} - {1'b0, b};
    else     s = {1'b0, a} + {1'b0, b};
    e.res = s[W-1:0];
    e.co  = sub ? (a >= b) : s[W];
    if (sub) e.ov = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
    else     e.ov = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
    return e;
  endfunction

  // Called at the negedge right after the accepting edge; returns how many
  // negedges later done was seen (-1 if never) and how many busy samples.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int j = 0; j <= W + 4; j++) begin
      if (j > 0) @(negedge clk);
      if (done) begin
        lat = j;
        break;
      end
      bcnt += int'(busy);
    end
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_result"}, 32'(result), 32'(e.res));
    check({tag, "_carry"}, 32'(carry_out), 32'(e.co));
`ifdef SERIAL_ADDSUB_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(e.ov));
`endif
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input exp_t e);
    int lat;
    int bcnt;
    @(negedge clk);
    a_in   = a;
    b_in   = b;
    sub_in = sub;
    start  = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    a_in   = W'($urandom);
    b_in   = W'($urandom);
    sub_in = 1'($urandom);
    wait_done(lat, bcnt);
    check({tag, "_latency"}, 32'(lat), 32'(W));
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'(W));
    check_result(tag);
    @(negedge clk);
    check({tag, "_done_width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    int bcnt;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;

    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    sub_in = 1'b0;
    a_in   = '0;
    b_in   = '0;

    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_carry", 32'(carry_out), 32'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
    check("reset_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases with hand-computed expectations.
    do_op("add_3c_0f", 8'h3C, 8'h0F, 1'b0, '{res: 8'h4B, co: 1'b0, ov: 1'b0});
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, '{res: 8'h00, co: 1'b1, ov: 1'b0});
    do_op("add_7f_01", 8'h7F, 8'h01, 1'b0, '{res: 8'h80, co: 1'b0, ov: 1'b1});
    do_op("sub_10_01", 8'h10, 8'h01, 1'b1, '{res: 8'h0F, co: 1'b1, ov: 1'b0});
    do_op("sub_01_02", 8'h01, 8'h02, 1'b1, '{res: 8'hFF, co: 1'b0, ov: 1'b0});
    do_op("sub_80_01", 8'h80, 8'h01, 1'b1, '{res: 8'h7F, co: 1'b1, ov: 1'b1});

    // start held high throughout: operands during SHIFT/DONE must be ignored.
    @(negedge clk);
    a_in   = 8'h20;
    b_in   = 8'h05;
    sub_in = 1'b0;
    start  = 1'b1;
    sb_q.push_back('{res: 8'h25, co: 1'b0, ov: 1'b0});
    @(posedge clk);
    @(negedge clk);
    a_in   = 8'hAA;
    b_in   = 8'h55;
    sub_in = 1'b1;
    wait_done(lat, bcnt);
    check("hold_first_latency", 32'(lat), 32'(W));
    check_result("hold_first");
    a_in   = 8'h33;
    b_in   = 8'h11;
    sub_in = 1'b1;
    sb_q.push_back('{res: 8'h22, co: 1'b1, ov: 1'b0});
    @(negedge clk);
    check("hold_idle_busy", 32'(busy), 32'd0);
    check("hold_idle_done", 32'(done), 32'd0);
    check("hold_idle_result", 32'(result), 32'h25);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("hold_second_accepted", 32'(busy), 32'd1);
    wait_done(lat, bcnt);
    check("hold_second_latency", 32'(lat), 32'(W));
    check_result("hold_second");
    @(negedge clk);

    // Reset in the middle of a SHIFT: outputs clear at once, no done follows.
    @(negedge clk);
    a_in   = 8'h3C;
    b_in   = 8'h0F;
    sub_in = 1'b0;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_carry", 32'(carry_out), 32'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
    check("midrst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      check("midrst_no_done", 32'(done), 32'd0);
    end
    do_op("post_rst_01_01", 8'h01, 8'h01, 1'b0, '{res: 8'h02, co: 1'b0, ov: 1'b0});

    // Random back-to-back operations against the reference model.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      do_op("rand", ra, rb, rs, model(ra, rb, rs));
    end

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
